// File: rtl/blinds_motor_ctrl.sv
// Roller-blind motor controller: accepts a level request, drives the motor
// toward the target position with a step prescaler and an emergency stop.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_level   level request (00/01/10/11), req_ready handshake
//   stop                  emergency stop, level sensitive
//   motor_up/motor_down   motor drive, busy = either
//   position              tracked blind position, 0 = closed
//   done/aborted          one-cycle completion / stop-halt pulses
module blinds_motor_ctrl #(
    parameter int STEPS_PER_QUARTER = 4,
    parameter int MOVE_DIV          = 8,
    localparam int POS_W = $clog2(4*STEPS_PER_QUARTER+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [1:0]       req_level,
    output logic             req_ready,
    input  logic             stop,
    output logic             motor_up,
    output logic             motor_down,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int PW = $clog2(MOVE_DIV);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        HALT
    } state_t;

    state_t           state, state_n;
    logic [POS_W-1:0] pos_q, pos_n;
    logic [POS_W-1:0] tgt_q, tgt_n;
    logic [POS_W-1:0] req_tgt;
    logic [POS_W-1:0] pos_step;
    logic [PW-1:0]    presc_q, presc_n;
    logic             done_q, done_n;
    logic             aborted_q, aborted_n;
    logic             wrap;

    // Fully open is four quarters, not three.
    always_comb begin
        req_tgt = '0;
        unique case (req_level)
            2'b00:   req_tgt = '0;
            2'b01:   req_tgt = POS_W'(STEPS_PER_QUARTER);
            2'b10:   req_tgt = POS_W'(2*STEPS_PER_QUARTER);
            default: req_tgt = POS_W'(4*STEPS_PER_QUARTER);
        endcase
    end

    assign wrap     = (presc_q == PW'(MOVE_DIV-1));
    assign pos_step = (state == MOVE_UP) ? pos_q + POS_W'(1)
                                         : pos_q - POS_W'(1);

    always_comb begin
        state_n   = state;
        pos_n     = pos_q;
        tgt_n     = tgt_q;
        presc_n   = presc_q;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    tgt_n   = req_tgt;
                    presc_n = '0;
                    if (req_tgt > pos_q)
                        state_n = MOVE_UP;
                    else if (req_tgt < pos_q)
                        state_n = MOVE_DOWN;
                    else
                        done_n = 1'b1;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                // stop wins over a step landing on the same edge
                if (stop) begin
                    state_n   = HALT;
                    presc_n   = '0;
                    aborted_n = 1'b1;
                end else if (wrap) begin
                    presc_n = '0;
                    pos_n   = pos_step;
                    if (pos_step == tgt_q) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    presc_n = presc_q + PW'(1);
                end
            end
            HALT: begin
                if (!stop)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pos_q     <= '0;
            tgt_q     <= '0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_n;
            pos_q     <= pos_n;
            tgt_q     <= tgt_n;
            presc_q   <= presc_n;
            done_q    <= done_n;
            aborted_q <= aborted_n;
        end
    end

    assign req_ready  = (state == IDLE) && !stop;
    assign motor_up   = (state == MOVE_UP);
    assign motor_down = (state == MOVE_DOWN);
    assign busy       = motor_up | motor_down;
    assign position   = pos_q;
    assign done       = done_q;
    assign aborted    = aborted_q;

endmodule

// File: tb/tb_blinds_motor_ctrl.sv
// Bench for blinds_motor_ctrl: directed scenarios plus random traffic,
// checked every cycle against an event-scheduled behavioural model.
module tb_blinds_motor_ctrl;

    localparam int SPQ  = 4;
    localparam int DIV  = 8;
    localparam int FULL = 4*SPQ;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_level = 2'b00;
    logic       stop = 1'b0;
    logic       req_ready;
    logic       motor_up;
    logic       motor_down;
    logic [4:0] position;
    logic       busy;
    logic       done;
    logic       aborted;

    blinds_motor_ctrl #(
        .STEPS_PER_QUARTER(SPQ),
        .MOVE_DIV(DIV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_level(req_level),
        .req_ready(req_ready),
        .stop(stop),
        .motor_up(motor_up),
        .motor_down(motor_down),
        .position(position),
        .busy(busy),
        .done(done),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // model: mode, position, target, edge index of the next scheduled step
    typedef enum {M_IDLE, M_UP, M_DN, M_HALT} mode_t;
    mode_t m_st = M_IDLE;
    int m_pos = 0, m_tgt = 0, m_next = 0, m_done = 0, m_ab = 0;
    int edge_n = 0;
    int up_cnt = 0, dn_cnt = 0, done_cnt = 0, ab_cnt = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic int tmap(input int l);
        case (l)
            0:       return 0;
            1:       return SPQ;
            2:       return 2*SPQ;
            default: return FULL;
        endcase
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_pos = 0; m_tgt = 0; m_done = 0; m_ab = 0;
    endtask

    task automatic model_edge(input logic v, input logic [1:0] l,
                              input logic s);
        int t;
        edge_n++;
        m_done = 0;
        m_ab = 0;
        case (m_st)
            M_IDLE: if (!s && v) begin
                t = tmap(int'(l));
                m_tgt = t;
                if (t == m_pos) m_done = 1;
                else begin
                    m_st = (t > m_pos) ? M_UP : M_DN;
                    m_next = edge_n + DIV;
                end
            end
            M_UP, M_DN: begin
                if (s) begin
                    m_st = M_HALT;
                    m_ab = 1;
                end else if (edge_n == m_next) begin
                    m_pos += (m_st == M_UP) ? 1 : -1;
                    m_next += DIV;
                    if (m_pos == m_tgt) begin
                        m_st = M_IDLE;
                        m_done = 1;
                    end
                end
            end
            M_HALT: if (!s) m_st = M_IDLE;
            default: m_st = M_IDLE;
        endcase
    endtask

    task automatic sample();
        chk("position", int'(position), m_pos);
        chk("motor_up", int'(motor_up), int'(m_st == M_UP));
        chk("motor_down", int'(motor_down), int'(m_st == M_DN));
        chk("busy", int'(busy), int'(m_st == M_UP || m_st == M_DN));
        chk("done", int'(done), m_done);
        chk("aborted", int'(aborted), m_ab);
        chk("req_ready", int'(req_ready),
            int'(m_st == M_IDLE && !stop));
        chk("pos_range", int'(position <= 5'(FULL)), 1);
        chk("one_motor", int'(motor_up & motor_down), 0);
        if (motor_up) up_cnt++;
        if (motor_down) dn_cnt++;
        if (done) done_cnt++;
        if (aborted) ab_cnt++;
    endtask

    task automatic step(input logic v, input logic [1:0] l, input logic s);
        @(negedge clk);
        sample();
        req_valid = v;
        req_level = l;
        stop = s;
        @(posedge clk);
        model_edge(v, l, s);
    endtask

    task automatic clr();
        up_cnt = 0; dn_cnt = 0; done_cnt = 0; ab_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        stop = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_pos", int'(position), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 2'b00, 1'b0);
    endtask

    // reset dropped between edges; outputs must clear without a clock
    task automatic async_rst();
        @(negedge clk);
        sample();
        req_valid = 1'b0;
        stop = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pos", int'(position), 0);
        chk("arst_up", int'(motor_up), 0);
        chk("arst_down", int'(motor_down), 0);
        chk("arst_busy", int'(busy), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 2'b00, 1'b0);
    endtask

    task automatic run_to(input int p);
        int g = 0;
        while (m_pos != p && g < 300) begin
            step(1'b0, 2'b00, 1'b0);
            g++;
        end
        chk("reach_budget", int'(g < 300), 1);
    endtask

    initial begin
        int stop_left = 0;
        do_reset();

        // full open from closed
        clr();
        step(1'b1, 2'b11, 1'b0);
        repeat (130) step(1'b0, 2'b00, 1'b0);
        #1;
        chk("s1_up_cycles", up_cnt, 128);
        chk("s1_done_cnt", done_cnt, 1);
        chk("s1_pos", int'(position), 16);

        // 16 -> quarter
        clr();
        step(1'b1, 2'b01, 1'b0);
        repeat (100) step(1'b0, 2'b00, 1'b0);
        #1;
        chk("s2_down_cycles", dn_cnt, 96);
        chk("s2_up_cycles", up_cnt, 0);
        chk("s2_done_cnt", done_cnt, 1);
        chk("s2_pos", int'(position), 4);

        // same level again
        clr();
        step(1'b1, 2'b01, 1'b0);
        repeat (3) step(1'b0, 2'b00, 1'b0);
        #1;
        chk("s3_motor", up_cnt + dn_cnt, 0);
        chk("s3_done_cnt", done_cnt, 1);
        chk("s3_pos", int'(position), 4);

        // stop at 7, then resume to half
        do_reset();
        step(1'b1, 2'b10, 1'b0);
        run_to(7);
        clr();
        repeat (5) step(1'b0, 2'b00, 1'b1);
        #1;
        chk("s4_abort_cnt", ab_cnt, 1);
        chk("s4_hold_pos", int'(position), 7);
        clr();
        step(1'b0, 2'b00, 1'b0);
        step(1'b1, 2'b10, 1'b0);
        repeat (12) step(1'b0, 2'b00, 1'b0);
        #1;
        chk("s4_up_cycles", up_cnt, 8);
        chk("s4_done_cnt", done_cnt, 1);
        chk("s4_pos", int'(position), 8);

        // requests during a move are ignored
        do_reset();
        clr();
        step(1'b1, 2'b11, 1'b0);
        repeat (120)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
        repeat (15) step(1'b0, 2'b00, 1'b0);
        #1;
        chk("s5_done_cnt", done_cnt, 1);
        chk("s5_pos", int'(position), 16);

        // async reset mid-move at position 9
        do_reset();
        step(1'b1, 2'b11, 1'b0);
        run_to(9);
        step(1'b0, 2'b00, 1'b0);
        async_rst();
        step(1'b0, 2'b00, 1'b0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic s;
            if (stop_left == 0 && $urandom_range(0, 99) < 2)
                stop_left = $urandom_range(1, 10);
            s = (stop_left > 0);
            if (stop_left > 0) stop_left--;
            if (i % 800 == 799)
                async_rst();
            else
                step(1'($urandom_range(0, 99) < 30),
                     2'($urandom_range(0, 3)), s);
        end
        step(1'b0, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
